// File: rtl/bitstream_accumulator.sv
// Counts the ones in each N-sample frame of a sigma-delta bitstream aligned to an external mod-N counter.
// Optional feature macro BITSTREAM_ACC_OVERRUN_HOLD_EN: on overrun keep the unread result and raise sticky o_ovr.
module bitstream_accumulator #(
    parameter int CW = 4,
    parameter int N  = 10,
    parameter int OW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_bit,
    input  logic [CW-1:0] i_cnt,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_valid,
    output logic          o_err,
    output logic          o_ovr
);

    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    ACCUM    = 1'b1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    logic [0:0]    state;
    logic [OW-1:0] acc;
    logic [CW-1:0] exp_cnt;

    logic          cnt_match;
    logic          frame_end;
    logic          sync_loss;
    logic [OW-1:0] bit_ext;
    logic [OW-1:0] result;

    always_comb begin
        bit_ext   = {{(OW-1){1'b0}}, i_bit};
        result    = acc + bit_ext;
        cnt_match = (i_cnt == exp_cnt);
        frame_end = i_en && (state == ACCUM) && cnt_match && (exp_cnt == LAST_CNT);
        sync_loss = i_en && (state == ACCUM) && !cnt_match;
    end

    // Frame tracker: follows the upstream counter, drops back to IDLE on any count it did not expect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            acc     <= '0;
            exp_cnt <= '0;
        end else if (i_en) begin
            case (state)
                IDLE: begin
                    if (i_cnt == '0) begin
                        acc     <= bit_ext;
                        exp_cnt <= CW'(1);
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!cnt_match) begin
                        acc     <= '0;
                        exp_cnt <= '0;
                        state   <= IDLE;
                    end else if (exp_cnt == LAST_CNT) begin
                        acc     <= '0;
                        exp_cnt <= '0;
                    end else begin
                        acc     <= result;
                        exp_cnt <= exp_cnt + CW'(1);
                    end
                end
                default: begin
                    acc     <= '0;
                    exp_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else begin
            o_err <= sync_loss;
        end
    end

`ifdef BITSTREAM_ACC_OVERRUN_HOLD_EN
    logic ovr_q;

    // An unread result that is not being consumed this edge wins over the new one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (frame_end) begin
            if (o_valid && !i_ready) begin
                ovr_q <= 1'b1;
            end else begin
                o_data  <= result;
                o_valid <= 1'b1;
            end
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign o_ovr = ovr_q;
`else
    // A new result always replaces the held one, so overrun is never reported.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (frame_end) begin
            o_data  <= result;
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign o_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_bitstream_accumulator.sv
// Self-checking bench for bitstream_accumulator: vector table, directed corner sequences and random traffic
// compared against a frame-level reference model.
module tb_bitstream_accumulator;

    localparam int CW = 4;
    localparam int N  = 10;
    localparam int OW = 8;

    logic          i_clk;
    logic          i_rst;
    logic          i_en;
    logic          i_bit;
    logic [CW-1:0] i_cnt;
    logic          i_ready;
    logic [OW-1:0] o_data;
    logic          o_valid;
    logic          o_err;
    logic          o_ovr;

    int checks = 0;
    int errors = 0;

    // Reference model state: collected bits of the frame in progress plus the output register view.
    bit m_sync;
    bit m_frame[$];
    int m_data;
    bit m_valid;
    bit m_err;
    bit m_ovr;

    typedef struct {
        bit en;
        bit b;
        int cnt;
        bit ready;
        int want_data;
        bit want_valid;
        bit want_err;
    } vec_t;

    vec_t vecs[$];

    bitstream_accumulator #(.CW(CW), .N(N), .OW(OW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_bit   (i_bit),
        .i_cnt   (i_cnt),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_err   (o_err),
        .o_ovr   (o_ovr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic modelReset();
        m_sync  = 1'b0;
        m_frame.delete();
        m_data  = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // A frame is simply the list of bits seen so far; the next expected count is its length.
    task automatic modelStep(input bit en, input bit b, input int cnt, input bit ready);
        bit got = 1'b0;
        bit err = 1'b0;
        int res = 0;
        if (en) begin
            if (!m_sync) begin
                if (cnt == 0) begin
                    m_frame.delete();
                    m_frame.push_back(b);
                    m_sync = 1'b1;
                end
            end else if (cnt == m_frame.size()) begin
                m_frame.push_back(b);
                if (m_frame.size() == N) begin
                    foreach (m_frame[i]) res += int'(m_frame[i]);
                    got = 1'b1;
                    m_frame.delete();
                end
            end else begin
                m_sync = 1'b0;
                m_frame.delete();
                err = 1'b1;
            end
        end
        if (got) begin
`ifdef BITSTREAM_ACC_OVERRUN_HOLD_EN
            if (m_valid && !ready) begin
                m_ovr = 1'b1;
            end else begin
                m_data  = res;
                m_valid = 1'b1;
            end
`else
            m_data  = res;
            m_valid = 1'b1;
`endif
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        m_err = err;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".data"},  32'(o_data),  32'(m_data));
        checkVal({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
        checkVal({tag, ".err"},   32'(o_err),   32'(m_err));
        checkVal({tag, ".ovr"},   32'(o_ovr),   32'(m_ovr));
    endtask

    task automatic applyStimulus(input bit en, input bit b, input int cnt, input bit ready, input string tag);
        i_en    = en;
        i_bit   = b;
        i_cnt   = cnt[CW-1:0];
        i_ready = ready;
        @(posedge i_clk);
        modelStep(en, b, cnt, ready);
        #1;
        checkOutput(tag);
    endtask

    // Reset is raised between clock edges so the zeroed outputs can only come from the async path.
    task automatic applyReset(input string tag);
        i_rst = 1'b1;
        #2;
        checkVal({tag, ".rst_data"},  32'(o_data),  32'd0);
        checkVal({tag, ".rst_valid"}, 32'(o_valid), 32'd0);
        checkVal({tag, ".rst_err"},   32'(o_err),   32'd0);
        checkVal({tag, ".rst_ovr"},   32'(o_ovr),   32'd0);
        modelReset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        int rc;
        bit en;
        bit rdy;

        i_rst   = 1'b0;
        i_en    = 1'b0;
        i_bit   = 1'b0;
        i_cnt   = '0;
        i_ready = 1'b0;
        modelReset();

        // Alternating 1,0 frame, consume, then a sync loss and an ignored count while idle.
        for (int i = 0; i < N; i++) begin
            vecs.push_back('{en: 1'b1, b: (i % 2 == 0), cnt: i, ready: 1'b1,
                             want_data: (i == N-1) ? 5 : 0, want_valid: (i == N-1), want_err: 1'b0});
        end
        vecs.push_back('{en: 1'b0, b: 1'b0, cnt: 0, ready: 1'b1, want_data: 5, want_valid: 1'b0, want_err: 1'b0});
        vecs.push_back('{en: 1'b1, b: 1'b1, cnt: 0, ready: 1'b1, want_data: 5, want_valid: 1'b0, want_err: 1'b0});
        vecs.push_back('{en: 1'b1, b: 1'b1, cnt: 5, ready: 1'b1, want_data: 5, want_valid: 1'b0, want_err: 1'b1});
        vecs.push_back('{en: 1'b1, b: 1'b1, cnt: 2, ready: 1'b1, want_data: 5, want_valid: 1'b0, want_err: 1'b0});

        #3;
        applyReset("init");

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].en, vecs[k].b, vecs[k].cnt, vecs[k].ready, "vec");
            checkVal($sformatf("vec%0d.data", k),  32'(o_data),  32'(vecs[k].want_data));
            checkVal($sformatf("vec%0d.valid", k), 32'(o_valid), 32'(vecs[k].want_valid));
            checkVal($sformatf("vec%0d.err", k),   32'(o_err),   32'(vecs[k].want_err));
        end

        // Two frames of all ones with ready high: valid for exactly one cycle after each frame end.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, i, 1'b1, "ones");
            checkVal("ones.data", 32'(o_data), 32'd10);
            checkVal("ones.valid_set", 32'(o_valid), 32'd1);
            applyStimulus(1'b0, 1'b0, 0, 1'b1, "ones_gap");
            checkVal("ones.valid_clr", 32'(o_valid), 32'd0);
        end

        // Release mid-count: the partial 4..9 run must not produce a result.
        applyReset("midstart");
        for (int i = 4; i < N; i++) applyStimulus(1'b1, 1'b1, i, 1'b1, "partial");
        checkVal("partial.valid", 32'(o_valid), 32'd0);
        for (int i = 0; i < N; i++) applyStimulus(1'b1, (i % 2 == 0), i, 1'b1, "after_partial");
        checkVal("after_partial.data", 32'(o_data), 32'd5);

        // Two unread frames of 7 then 3 ones.
        applyReset("overrun");
        for (int i = 0; i < N; i++) applyStimulus(1'b1, (i < 7), i, 1'b0, "ovr_f1");
        for (int i = 0; i < N; i++) applyStimulus(1'b1, (i < 3), i, 1'b0, "ovr_f2");
`ifdef BITSTREAM_ACC_OVERRUN_HOLD_EN
        checkVal("ovr.data", 32'(o_data), 32'd7);
        checkVal("ovr.flag", 32'(o_ovr),  32'd1);
`else
        checkVal("ovr.data", 32'(o_data), 32'd3);
        checkVal("ovr.flag", 32'(o_ovr),  32'd0);
`endif
        checkVal("ovr.valid", 32'(o_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, "ovr_drain");

        // Count jumps 3 -> 6: one-cycle error, no result, resync at the next zero.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, i, 1'b1, "jump_pre");
        applyStimulus(1'b1, 1'b1, 6, 1'b1, "jump");
        checkVal("jump.err", 32'(o_err), 32'd1);
        checkVal("jump.valid", 32'(o_valid), 32'd0);
        for (int i = 7; i < N; i++) applyStimulus(1'b1, 1'b1, i, 1'b1, "jump_post");
        checkVal("jump.err_clr", 32'(o_err), 32'd0);
        checkVal("jump.no_result", 32'(o_valid), 32'd0);
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, i, 1'b1, "resync");
        checkVal("resync.data", 32'(o_data), 32'd10);

        // Enable toggling every cycle through a frame of ones.
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, 1'b1, i, 1'b1, "toggle_on");
            applyStimulus(1'b0, 1'b0, (i + 1) % N, 1'b1, "toggle_off");
        end
        checkVal("toggle.data", 32'(o_data), 32'd10);

        // Reset pulsed while i_cnt=5, then the rest of that frame must be ignored.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, i, 1'b1, "rst_pre");
        i_cnt = CW'(5);
        applyReset("rst_mid");
        for (int i = 6; i < N; i++) applyStimulus(1'b1, 1'b1, i, 1'b1, "rst_post");
        checkVal("rst_mid.no_result", 32'(o_valid), 32'd0);
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b1, i, 1'b1, "rst_new");
        checkVal("rst_new.data", 32'(o_data), 32'd10);

        // Random traffic: mostly well-behaved counter, occasional jumps, stalls and resets.
        rc = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) applyReset("rand_rst");
            if ($urandom_range(0, 39) == 0) rc = $urandom_range(0, 15);
            en  = ($urandom_range(0, 3) != 0);
            rdy = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            applyStimulus(en, 1'($urandom_range(0, 1)), rc, rdy, "rand");
            if (en) rc = (rc + 1) % N;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitstream_accumulator.md
BITSTREAM_ACCUMULATOR -- requirements
Module: bitstream_accumulator

Interface
REQ-001 SHALL have parameter CW, default 4, width of the frame-counter input.
REQ-002 SHALL have parameter N, default 10, frame length in enabled clocks; legal range 2..2^CW.
REQ-003 SHALL have parameter OW, default 8, output width; legal when 2^OW > N.
REQ-004 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_en  input  1  sample enable, shared with the upstream mod-N frame counter.
REQ-007 SHALL have port i_bit  input  1  sigma-delta bitstream sample.
REQ-008 SHALL have port i_cnt  input  CW  current frame-counter value.
REQ-009 SHALL have port i_ready  input  1  downstream accepts o_data.
REQ-010 SHALL have port o_data  output  OW  ones-count of the last complete frame.
REQ-011 SHALL have port o_valid  output  1  o_data holds an unconsumed result.
REQ-012 SHALL have port o_err  output  1  one-cycle pulse on a frame-sync loss.
REQ-013 SHALL have port o_ovr  output  1  sticky overrun flag.

Function
REQ-014 SHALL implement FSM states IDLE and ACCUM, plus internal accumulator acc[OW-1:0] and expected count exp[CW-1:0].
REQ-015 When i_en=0, acc, exp and state SHALL hold; the output handshake SHALL still operate.
REQ-016 In IDLE with i_en=1 and i_cnt=0: acc<=i_bit, exp<=1, state<=ACCUM; any other i_cnt in IDLE SHALL be ignored.
REQ-017 In ACCUM with i_en=1 and i_cnt=exp<N-1: acc<=acc+i_bit, exp<=exp+1.
REQ-018 In ACCUM with i_en=1 and i_cnt=exp=N-1 (frame end): result=acc+i_bit is offered to the output register, acc<=0, exp<=0, state stays ACCUM.
REQ-019 In ACCUM with i_en=1 and i_cnt!=exp: acc<=0, state<=IDLE, no result offered, o_err=1 for exactly the next cycle.
REQ-020 A result offered at edge k SHALL appear on o_data with o_valid=1 after edge k (latency one clock from the last frame bit).
REQ-021 o_data SHALL be stable while o_valid=1; o_valid SHALL clear on the edge where o_valid=1 and i_ready=1, unless a new result loads on that same edge.
REQ-022 Frame end with o_valid=1 and i_ready=1 on the same edge: new result SHALL load, o_valid stays 1, no overrun.
REQ-023 Frame end with o_valid=0: result loads, o_valid<=1.
REQ-024 Frame end with o_valid=1 and i_ready=0 is an overrun; behaviour per REQ-029/REQ-030.
REQ-025 acc arithmetic SHALL be unsigned OW-bit; no saturation is required (max count N < 2^OW).

Reset
REQ-026 On i_rst=1, immediately and independent of i_clk: state=IDLE, acc=0, exp=0, o_data=0, o_valid=0, o_err=0, o_ovr=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, accumulation SHALL restart only at the next i_cnt=0 with i_en=1.
REQ-028 o_ovr SHALL clear only on reset.

Configuration
REQ-029 With macro BITSTREAM_ACC_OVERRUN_HOLD_EN defined: on overrun, o_data SHALL keep the old result, the new result SHALL be dropped, and o_ovr SHALL be set to 1 (sticky).
REQ-030 Without BITSTREAM_ACC_OVERRUN_HOLD_EN: on overrun, o_data SHALL be overwritten with the new result, o_valid stays 1, and o_ovr SHALL be tied to 0.

Verification
REQ-031 N=10, i_en=1, i_cnt cycling 0..9, i_bit=1 on all bits, i_ready=1 -> o_data=10, o_valid=1 for one cycle after each i_cnt=9 edge.
REQ-032 i_bit pattern 1,0 alternating over one frame starting at i_cnt=0 -> o_data=5; frame starting mid-count (release at i_cnt=4) -> first result only after the next full 0..9 frame.
REQ-033 i_ready=0 for two frames with counts 7 then 3 -> with macro: o_data=7, o_ovr=1; without macro: o_data=3, o_ovr=0; o_valid=1 in both cases.
REQ-034 i_cnt jumps 3->6 during ACCUM -> o_err pulses one cycle, no o_valid, resync at next i_cnt=0.
REQ-035 i_en toggling 1,0 every cycle through a full frame of ones -> o_data=10; i_rst pulsed at i_cnt=5 -> all outputs 0 asynchronously, next result only after a complete new frame.
